// File: rtl/phy_regfile_wb_arbiter.sv
// Round-robin arbiter sharing the physical regfile commit write port among writeback
// producers, with a registered write stage and a per-register ready scoreboard.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module phy_regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned PHY_REG_W = `PHYSICAL_REG_NUM_WIDTH,
    parameter int unsigned VAL_W     = `REG_VAL_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*PHY_REG_W-1:0]   req_phy_reg,
    input  logic [NUM_REQ*VAL_W-1:0]       req_val,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           alloc_en,
    input  logic [PHY_REG_W-1:0]           alloc_phy_reg,
    output logic                           commit_wr_en,
    output logic [PHY_REG_W-1:0]           wr_commit_reg,
    output logic [VAL_W-1:0]               commit_wr_val,
    output logic [(2**PHY_REG_W)-1:0]      phy_ready_vec
);

    localparam int unsigned PHY_REG_NUM = 2**PHY_REG_W;
    localparam int unsigned PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [PHY_REG_W-1:0]   grant_reg;
    logic [VAL_W-1:0]       grant_val;
    logic [PHY_REG_NUM-1:0] ready_nxt;
    int unsigned            idx;

    // Scan from rr_ptr, wrapping; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_reg = '0;
        grant_val = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = k + 32'(rr_ptr);
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any      = 1'b1;
                req_ready[idx] = 1'b1;
                grant_idx      = PTR_W'(idx);
                grant_reg      = req_phy_reg[idx*PHY_REG_W +: PHY_REG_W];
                grant_val      = req_val[idx*VAL_W +: VAL_W];
            end
        end
    end

    // Allocation is applied after the commit set so a same-index clear wins.
    always_comb begin
        ready_nxt = phy_ready_vec;
        if (commit_wr_en) begin
            ready_nxt[wr_commit_reg] = 1'b1;
        end
        if (alloc_en) begin
            ready_nxt[alloc_phy_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr        <= '0;
            commit_wr_en  <= 1'b0;
            wr_commit_reg <= '0;
            commit_wr_val <= '0;
        end else begin
            commit_wr_en <= grant_any;
            if (grant_any) begin
                rr_ptr        <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                wr_commit_reg <= grant_reg;
                commit_wr_val <= grant_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phy_ready_vec <= '1;
        end else begin
            phy_ready_vec <= ready_nxt;
        end
    end

endmodule
